// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation input-conditioning stage:
// level FSM encoding, default filter lengths and the level-consistency rule.
package irrig_pkg;

   // Level supervision states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } lvl_state_t;

   // Default number of stable synchronised samples before a filtered output moves.
   localparam int DEB_CYCLES_DEF   = 8;
   // Default number of consecutive inconsistent level triples before a fault latches.
   localparam int FAULT_CYCLES_DEF = 16;

   // A tank cannot read "high" without "mid", nor "mid" without "low".
   function automatic logic lvl_inconsistent(input logic a, input logic m, input logic b);
      return (a & ~m) | (m & ~b);
   endfunction

endpackage

// File: rtl/filtro_deb.sv
// One conditioned input: 2-FF synchroniser followed by a debounce counter.
// The filtered value only moves after DEB_CYCLES consecutive synchronised
// samples that disagree with it; any agreeing sample restarts the count.
module filtro_deb
   import irrig_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic filt_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Debounce decision: count disagreeing samples, commit on the DEB_CYCLES-th.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (sync2_q == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         filt_d = sync2_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Synchroniser, counter and filtered-value registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/condicionador_sensores.sv
// Input-conditioning stage in front of the irrigation core. Six debounced
// inputs; the tank-level triple is supervised by a small FSM that masks
// impossible patterns and latches a fault when they persist, until ACK.
module condicionador_sensores
   import irrig_pkg::*;
#(
   parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
   parameter int FAULT_CYCLES = FAULT_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic A_RAW,
   input  logic M_RAW,
   input  logic B_RAW,
   input  logic US_RAW,
   input  logic UA_RAW,
   input  logic T_RAW,
   input  logic ACK,
   output logic A,
   output logic M,
   output logic B,
   output logic US,
   output logic UA,
   output logic T,
   output logic FAULT,
   output logic VALID
);

   localparam int FCW = $clog2(FAULT_CYCLES + 1);
   localparam int SCW = $clog2(DEB_CYCLES + 3);
   localparam logic [FCW-1:0] FCNT_LAST = FCW'(FAULT_CYCLES - 1);
   localparam logic [SCW-1:0] SCNT_DONE = SCW'(DEB_CYCLES + 2);

   // Bit order everywhere: {A, M, B, US, UA, T}.
   logic [5:0] raw_w;
   logic [5:0] filt_w;
   logic [2:0] triple_w;
   logic       inc_w;

   lvl_state_t     state_q, state_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [2:0]     last_q, last_d;
   logic [SCW-1:0] scnt_q, scnt_d;
   logic           valid_q, valid_d;

   assign raw_w = {A_RAW, M_RAW, B_RAW, US_RAW, UA_RAW, T_RAW};

   for (genvar gi = 0; gi < 6; gi++) begin : g_filt
      filtro_deb #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
         .clk_i  (CLK),
         .rst_i  (RST),
         .raw_i  (raw_w[gi]),
         .filt_o (filt_w[gi])
      );
   end

   assign triple_w = filt_w[5:3];
   assign inc_w    = lvl_inconsistent(triple_w[2], triple_w[1], triple_w[0]);

   // Level FSM next state: track consistent triples, count inconsistent ones.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      last_d  = last_q;
      unique case (state_q)
         ST_OK: begin
            if (inc_w) begin
               state_d = ST_SUSPECT;
               fcnt_d  = FCW'(1);
            end else begin
               last_d = triple_w;
            end
         end
         ST_SUSPECT: begin
            if (!inc_w) begin
               state_d = ST_OK;
               fcnt_d  = '0;
               last_d  = triple_w;
            end else begin
               fcnt_d = fcnt_q + FCW'(1);
               if (fcnt_q == FCNT_LAST) begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            // An acknowledge only counts once the switches read sane again.
            if (ACK && !inc_w) begin
               state_d = ST_OK;
               fcnt_d  = '0;
               last_d  = triple_w;
            end
         end
         default: begin
            state_d = ST_OK;
            fcnt_d  = '0;
         end
      endcase
   end

   // Startup timer: VALID once every filter has had time to settle.
   always_comb begin
      scnt_d  = scnt_q;
      valid_d = valid_q;
      if (!valid_q) begin
         scnt_d = scnt_q + SCW'(1);
         if (scnt_d == SCNT_DONE) begin
            valid_d = 1'b1;
         end
      end
   end

   // State, fault counter, last-consistent triple and startup registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_OK;
         fcnt_q  <= '0;
         last_q  <= '0;
         scnt_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         last_q  <= last_d;
         scnt_q  <= scnt_d;
         valid_q <= valid_d;
      end
   end

   // An impossible triple is never shown, even on the edge it first appears.
   always_comb begin
      {A, M, B} = last_q;
      if (state_q == ST_OK && !inc_w) begin
         {A, M, B} = triple_w;
      end
   end

   assign US    = filt_w[2];
   assign UA    = filt_w[1];
   assign T     = filt_w[0];
   assign FAULT = (state_q == ST_FAULT);
   assign VALID = valid_q;

endmodule

// File: tb/tb_condicionador_sensores.sv
// Bench for condicionador_sensores: directed table of phases with hand-derived
// end-of-phase values, hand-written reset sequences, and a randomized run.
// A behavioural model (sample history windows and run lengths) is checked
// on every edge.
module tb_condicionador_sensores;

   localparam int DEB = 8;
   localparam int FLT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ack = 1'b0;
   logic [5:0] raw = '0;   // {A, M, B, US, UA, T}
   logic       a, m, b, us, ua, t, fault, valid;

   int total = 0;
   int bad   = 0;

   // Clock
   always #5 clk = ~clk;

   condicionador_sensores #(.DEB_CYCLES(DEB), .FAULT_CYCLES(FLT)) dut (
      .CLK(clk), .RST(rst),
      .A_RAW(raw[5]), .M_RAW(raw[4]), .B_RAW(raw[3]),
      .US_RAW(raw[2]), .UA_RAW(raw[1]), .T_RAW(raw[0]),
      .ACK(ack),
      .A(a), .M(m), .B(b), .US(us), .UA(ua), .T(t),
      .FAULT(fault), .VALID(valid)
   );

   // ---------------- behavioural reference model ----------------
   logic [5:0] hist_q[$];   // raw samples taken at recent edges
   logic [5:0] sync_q[$];   // value seen by the filters at recent edges
   logic [5:0] mf    = '0;  // model filtered values
   int         mrun  = 0;   // consecutive inconsistent triples seen
   bit         mfault = 1'b0;
   logic [2:0] mlast = '0;
   int         medges = 0;

   // Physically possible tank readings: water fills from the bottom up.
   function automatic bit lvl_ok(input logic [2:0] tr);
      return (tr == 3'b000) || (tr == 3'b001) || (tr == 3'b011) || (tr == 3'b111);
   endfunction

   task automatic model_edge();
      logic [5:0] s;
      logic [2:0] tr;
      bit         all_diff;
      if (rst) begin
         hist_q.delete();
         sync_q.delete();
         mf = '0; mrun = 0; mfault = 1'b0; mlast = '0; medges = 0;
      end else begin
         tr = mf[5:3];
         if (mfault) begin
            if (ack && lvl_ok(tr)) begin
               mfault = 1'b0; mrun = 0; mlast = tr;
            end
         end else if (lvl_ok(tr)) begin
            mrun = 0; mlast = tr;
         end else begin
            mrun++;
            if (mrun == FLT) mfault = 1'b1;
         end
         // Two flops of synchronisation: the filter sees the sample from two edges back.
         s = (hist_q.size() >= 2) ? hist_q[hist_q.size()-2] : 6'b0;
         hist_q.push_back(raw);
         if (hist_q.size() > 2) void'(hist_q.pop_front());
         sync_q.push_back(s);
         if (sync_q.size() > DEB) void'(sync_q.pop_front());
         // A filtered bit flips once the last DEB seen samples all disagree with it.
         if (sync_q.size() == DEB) begin
            for (int bi = 0; bi < 6; bi++) begin
               all_diff = 1'b1;
               for (int j = 0; j < DEB; j++)
                  if (sync_q[j][bi] == mf[bi]) all_diff = 1'b0;
               if (all_diff) mf[bi] = ~mf[bi];
            end
         end
         medges++;
      end
   endtask

   function automatic logic [7:0] model_out();
      logic [2:0] lvl;
      lvl = (!mfault && mrun == 0 && lvl_ok(mf[5:3])) ? mf[5:3] : mlast;
      return {lvl, mf[2:0], mfault, (medges >= DEB + 2)};
   endfunction

   function automatic logic [7:0] dut_out();
      return {a, m, b, us, ua, t, fault, valid};
   endfunction

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [7:0] act);
      logic [7:0] e;
      e = exp_q.pop_front();
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL %s: got {A,M,B,US,UA,T,FAULT,VALID}=%b expected %b at %0t", name, act, e, $time);
      end
   endtask

   // ---------------- driver ----------------
   // One clock edge: advance the model, then compare #1 after the edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      exp_q.push_back(model_out());
      check("model", dut_out());
   endtask

   task automatic hand_check(input string name, input logic [7:0] e);
      exp_q.push_back(e);
      check(name, dut_out());
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [5:0] raw;
      logic       ack;
      int         cycles;
      logic [7:0] exp;    // {A,M,B,US,UA,T,FAULT,VALID} at the end of the phase
   } vec_t;

   vec_t tbl[21];
   int   hold[6];

   initial begin
      tbl[0]  = '{6'b000000, 1'b0, 12, 8'b00000001};  // settle, VALID up
      tbl[1]  = '{6'b000100, 1'b0,  7, 8'b00000001};  // short US pulse
      tbl[2]  = '{6'b000000, 1'b0,  1, 8'b00000001};  // toggle back
      tbl[3]  = '{6'b000100, 1'b0,  7, 8'b00000001};  // restarts from zero
      tbl[4]  = '{6'b000000, 1'b0, 10, 8'b00000001};
      tbl[5]  = '{6'b000100, 1'b0,  9, 8'b00000001};  // one edge short of latency
      tbl[6]  = '{6'b000100, 1'b0,  1, 8'b00010001};  // US=1 at edge 10
      tbl[7]  = '{6'b001100, 1'b0, 20, 8'b00110001};  // B
      tbl[8]  = '{6'b011100, 1'b0, 20, 8'b01110001};  // M
      tbl[9]  = '{6'b111100, 1'b0, 20, 8'b11110001};  // A
      tbl[10] = '{6'b011100, 1'b0, 20, 8'b01110001};  // back to 011
      tbl[11] = '{6'b101100, 1'b0, 25, 8'b01110001};  // 15 inconsistent edges
      tbl[12] = '{6'b101100, 1'b0,  1, 8'b01110011};  // 16th: FAULT
      tbl[13] = '{6'b101100, 1'b1,  3, 8'b01110011};  // ACK ignored while 101
      tbl[14] = '{6'b111100, 1'b0, 10, 8'b01110011};  // filtered 111, no ACK
      tbl[15] = '{6'b111100, 1'b1,  1, 8'b11110001};  // ACK clears, follows 111
      tbl[16] = '{6'b101100, 1'b0, 12, 8'b11110001};  // 2 inconsistent
      tbl[17] = '{6'b111100, 1'b0, 10, 8'b11110001};  // 10 more (12 total)
      tbl[18] = '{6'b111100, 1'b0,  2, 8'b11110001};  // one consistent sample
      tbl[19] = '{6'b101100, 1'b0, 25, 8'b11110001};  // count restarted: 15
      tbl[20] = '{6'b101100, 1'b0,  1, 8'b11110011};  // 16th: FAULT

      // Reset with all raw inputs high, then watch the 10-edge startup.
      raw = 6'b111111;
      pulse_reset();
      hand_check("reset_outputs", 8'b00000000);
      for (int i = 0; i < 9; i++) tick();
      hand_check("startup_edge9", 8'b00000000);
      tick();
      hand_check("startup_edge10", 8'b11111101);

      // Directed phases from a clean start.
      raw = 6'b000000;
      pulse_reset();
      hand_check("reset_again", 8'b00000000);
      for (int v = 0; v < 21; v++) begin
         raw = tbl[v].raw;
         ack = tbl[v].ack;
         for (int c = 0; c < tbl[v].cycles; c++) tick();
         hand_check($sformatf("phase%0d", v), tbl[v].exp);
      end
      ack = 1'b0;

      // Reset while FAULT is latched clears it on that very edge.
      pulse_reset();
      hand_check("reset_mid_fault", 8'b00000000);
      raw = 6'b000000;
      for (int i = 0; i < 12; i++) tick();
      hand_check("after_fault_reset", 8'b00000001);

      // Randomized: each raw input holds a value for a random time,
      // mixing glitches with long holds so faults can develop.
      for (int bi = 0; bi < 6; bi++) hold[bi] = 0;
      for (int c = 0; c < 5000; c++) begin
         for (int bi = 0; bi < 6; bi++) begin
            if (hold[bi] == 0) begin
               raw[bi]  = 1'($urandom_range(0, 1));
               hold[bi] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                      : int'($urandom_range(1, 12));
            end else begin
               hold[bi]--;
            end
         end
         ack = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 1999) == 0);
         tick();
      end
      rst = 1'b0;
      ack = 1'b0;

      // Report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
